mem_port_arbiter: RTL and testbench

Single-port arbiter for the 256×8 unified memory of the 8-bit pipelined processor. It shares the one memory port between three requesters:
- the data-memory stage (loads, stores, push/pop, interrupt/call vector traffic);
- the instruction-fetch stage;
- an optional loader/DMA port used to preload or inspect memory.

It grants at most one access per cycle, tracks which requester owns each read in flight, and guarantees fetch progress under sustained data traffic.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_arb_prio.sv | 23 ++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Optional loader/DMA requester is enabled with `MEM_ARB_DMA_EN.
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 8;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_STARVE_LIMIT = 4;

   // Owner of the read in flight; doubles as the arbiter state
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2,
      OWN_DMA  = 2'd3
   } own_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the arbiter; master = requesters/memory, slave = arbiter.
// Loader/DMA signals exist only with `MEM_ARB_DMA_EN.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_stall;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

`ifdef MEM_ARB_DMA_EN
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;
`endif

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_stall, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_DMA_EN
      , output dma_req, dma_we, dma_addr, dma_wdata
      , input  dma_gnt, dma_rvalid, dma_rdata
`endif
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_stall, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_DMA_EN
      , input  dma_req, dma_we, dma_addr, dma_wdata
      , output dma_gnt, dma_rvalid, dma_rdata
`endif
   );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational grant encoder: dm > dma > if, with a fetch override flag.
// One-hot grant vector: [0] fetch, [1] data stage, [2] loader.
module mem_arb_prio (
   input  logic       req_if,
   input  logic       req_dm,
   input  logic       req_dma,
   input  logic       ovr,
   output logic [2:0] gnt
);

   always_comb begin
      gnt = '0;
      if (ovr && req_if)
         gnt[0] = 1'b1;
      else if (req_dm)
         gnt[1] = 1'b1;
      else if (req_dma)
         gnt[2] = 1'b1;
      else if (req_if)
         gnt[0] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter for the 256x8 unified memory: fetch, data stage and optional loader.
// Loader port and priority level are built only with `MEM_ARB_DMA_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [2:0]        gnt;
   logic              req_if;
   logic              req_dm;
   logic              req_dma;
   logic              ovr;
   own_t              win;
   own_t              tag;
   own_t              tag_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic              cmd_en;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // Gating requests with rst keeps grants and the memory command low during reset
   assign req_if = bus.if_req & ~rst;
   assign req_dm = bus.dm_req & ~rst;
`ifdef MEM_ARB_DMA_EN
   assign req_dma = bus.dma_req & ~rst;
`else
   assign req_dma = 1'b0;
`endif

   assign ovr = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

   mem_arb_prio u_prio (
      .req_if  (req_if),
      .req_dm  (req_dm),
      .req_dma (req_dma),
      .ovr     (ovr),
      .gnt     (gnt)
   );

   always_comb begin
      win = OWN_NONE;
      if (gnt[0])
         win = OWN_IF;
      else if (gnt[1])
         win = OWN_DM;
      else if (gnt[2])
         win = OWN_DMA;
   end

   always_comb begin
      cmd_en    = 1'b0;
      cmd_we    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      case (win)
         OWN_IF: begin
            cmd_en   = 1'b1;
            cmd_addr = bus.if_addr;
         end
         OWN_DM: begin
            cmd_en    = 1'b1;
            cmd_we    = bus.dm_we;
            cmd_addr  = bus.dm_addr;
            cmd_wdata = bus.dm_wdata;
         end
`ifdef MEM_ARB_DMA_EN
         OWN_DMA: begin
            cmd_en    = 1'b1;
            cmd_we    = bus.dma_we;
            cmd_addr  = bus.dma_addr;
            cmd_wdata = bus.dma_wdata;
         end
`endif
         default: ;
      endcase
   end

   assign bus.mem_en    = cmd_en;
   assign bus.mem_we    = cmd_we;
   assign bus.mem_addr  = cmd_addr;
   assign bus.mem_wdata = cmd_wdata;

   // Read-owner tag: next state is the current winner for reads, none otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tag <= OWN_NONE;
      else
         tag <= tag_nxt;
   end

   always_comb begin
      tag_nxt = OWN_NONE;
      if (cmd_en && !cmd_we)
         tag_nxt = win;
   end

   always_comb begin
      starve_nxt = '0;
      if (bus.if_req && !gnt[0])
         starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else
         starve_cnt <= starve_nxt;
   end

   assign bus.if_gnt    = gnt[0];
   assign bus.if_stall  = bus.if_req & ~gnt[0];
   assign bus.if_rvalid = (tag == OWN_IF);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;

   assign bus.dm_gnt    = gnt[1];
   assign bus.dm_rvalid = (tag == OWN_DM);
   assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;

`ifdef MEM_ARB_DMA_EN
   assign bus.dma_gnt    = gnt[2];
   assign bus.dma_rvalid = (tag == OWN_DMA);
   assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;
`endif

   // A stalled requester must present the identical request until granted
   a_if_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.if_req && !bus.if_gnt) |=> (bus.if_req && $stable(bus.if_addr)));

   a_dm_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.dm_req && !bus.dm_gnt) |=>
         (bus.dm_req && $stable(bus.dm_we) && $stable(bus.dm_addr) && $stable(bus.dm_wdata)));

`ifdef MEM_ARB_DMA_EN
   a_dma_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.dma_req && !bus.dma_gnt) |=>
         (bus.dma_req && $stable(bus.dma_we) && $stable(bus.dma_addr) && $stable(bus.dma_wdata)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic against a rule-level model.
// Honours `MEM_ARB_DMA_EN for the loader port.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LIMIT = 4;

   typedef struct {
      int          cyc;
      logic [2:0]  g;      // {if, dm, dma}
      logic        st;
      logic [17:0] cmd;    // {en, we, addr, wdata}
   } gexp_t;

   typedef struct {
      int         due;
      int         own;     // 0 none, 1 if, 2 dm, 3 dma
      logic [7:0] d;
   } rexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   gexp_t      gnt_q[$];
   rexp_t      rd_q[$];
   logic [7:0] ref_mem [256];
   int         n_chk = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   int         mcyc  = 0;
   int         starve = 0;

   // candidate requests for the next step, and the values actually presented
   bit         c_if, c_dm, c_dwe, c_dma, c_awe;
   logic [7:0] c_ia, c_da, c_dwd, c_aa, c_awd;
   bit         h_if, h_dm, h_dwe, h_dma, h_awe;
   logic [7:0] h_ia, h_da, h_dwd, h_aa, h_awd;
   bit         p_if, p_dm, p_dma;

   // memory environment: registered read port, random junk when no read was issued
   initial begin
      logic [7:0] env_mem [256];
      for (int unsigned i = 0; i < 256; i++) env_mem[i] = 8'(i * 37 + 11);
      forever begin
         @(posedge clk);
         if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= env_mem[bus.mem_addr];
         else
            bus.mem_rdata <= 8'($urandom);
         if (bus.mem_en && bus.mem_we)
            env_mem[bus.mem_addr] = bus.mem_wdata;
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, mcyc, act, exp);
      end
   endfunction

   task automatic clear_cand();
      c_if = 0; c_dm = 0; c_dwe = 0; c_dma = 0; c_awe = 0;
      c_ia = '0; c_da = '0; c_dwd = '0; c_aa = '0; c_awd = '0;
   endtask

   task automatic step(input bit r);
      int         w;
      bit         en, we;
      logic [7:0] a, wd;
      gexp_t      ge;
      rexp_t      re;
      @(posedge clk);
      #1;
      rst = r;
      if (!p_if) begin h_if = c_if; h_ia = c_ia; end
      if (!p_dm) begin h_dm = c_dm; h_dwe = c_dwe; h_da = c_da; h_dwd = c_dwd; end
      if (!p_dma) begin h_dma = c_dma; h_awe = c_awe; h_aa = c_aa; h_awd = c_awd; end
      bus.if_req = h_if; bus.if_addr = h_ia;
      bus.dm_req = h_dm; bus.dm_we = h_dwe; bus.dm_addr = h_da; bus.dm_wdata = h_dwd;
`ifdef MEM_ARB_DMA_EN
      bus.dma_req = h_dma; bus.dma_we = h_awe; bus.dma_addr = h_aa; bus.dma_wdata = h_awd;
`endif
      // who should win this cycle
      w = 0;
      if (!r) begin
         if (LIMIT != 0 && starve == LIMIT && h_if) w = 1;
         else if (h_dm) w = 2;
         else if (h_dma) w = 3;
         else if (h_if) w = 1;
      end
      en = (w != 0); we = 0; a = '0; wd = '0;
      if (w == 1) a = h_ia;
      if (w == 2) begin we = h_dwe; a = h_da; wd = h_dwd; end
      if (w == 3) begin we = h_awe; a = h_aa; wd = h_awd; end
      ge.cyc = cyc;
      ge.g   = {w == 1, w == 2, w == 3};
      ge.st  = h_if && (w != 1);
      ge.cmd = {en, we, a, wd};
      gnt_q.push_back(ge);
      if (r) rd_q.delete();
      else if (en && !we) begin
         re.due = cyc + 1; re.own = w; re.d = ref_mem[a];
         rd_q.push_back(re);
      end else if (en) ref_mem[a] = wd;
      starve = (!r && h_if && w != 1) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      p_if  = h_if  && (w != 1);
      p_dm  = h_dm  && (w != 2);
      p_dma = h_dma && (w != 3);
      clear_cand();
      cyc++;
   endtask

   // monitor: compare whatever the DUT presents against the queued expectations
   initial begin
      gexp_t      e;
      rexp_t      re;
      logic [2:0] rv, ov, g;
      logic [7:0] rd_if, rd_dm, rd_dma, rd_sel;
      forever begin
         @(negedge clk);
         if (gnt_q.size() > 0) begin
            e = gnt_q.pop_front();
            mcyc = e.cyc;
`ifdef MEM_ARB_DMA_EN
            g = {bus.if_gnt, bus.dm_gnt, bus.dma_gnt};
            rv = {bus.if_rvalid, bus.dm_rvalid, bus.dma_rvalid};
            rd_dma = bus.dma_rdata;
`else
            g = {bus.if_gnt, bus.dm_gnt, 1'b0};
            rv = {bus.if_rvalid, bus.dm_rvalid, 1'b0};
            rd_dma = '0;
`endif
            rd_if = bus.if_rdata;
            rd_dm = bus.dm_rdata;
            chk("grant", 32'(g), 32'(e.g));
            chk("if_stall", 32'(bus.if_stall), 32'(e.st));
            chk("mem_cmd", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(e.cmd));
            re.own = 0; re.d = '0; re.due = 0;
            if (rd_q.size() > 0 && rd_q[0].due == e.cyc) re = rd_q.pop_front();
            ov = (re.own == 1) ? 3'b100 : (re.own == 2) ? 3'b010 : (re.own == 3) ? 3'b001 : 3'b000;
            chk("rvalid", 32'(rv), 32'(ov));
            rd_sel = (re.own == 1) ? rd_if : (re.own == 2) ? rd_dm : rd_dma;
            if (re.own != 0) chk("rdata", 32'(rd_sel), 32'(re.d));
            chk("rdata_idle", 32'({rv[2] ? 8'h00 : rd_if, rv[1] ? 8'h00 : rd_dm, rv[0] ? 8'h00 : rd_dma}), 32'(0));
         end
      end
   end

   initial begin
      for (int unsigned i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
      bus.if_req = 0; bus.if_addr = '0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
`ifdef MEM_ARB_DMA_EN
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
`endif
      h_if = 0; h_dm = 0; h_dma = 0; h_dwe = 0; h_awe = 0;
      h_ia = '0; h_da = '0; h_dwd = '0; h_aa = '0; h_awd = '0;
      p_if = 0; p_dm = 0; p_dma = 0;
      clear_cand();

      // reset with requests present: no grants
      c_if = 1; c_ia = 8'h07; step(1);
      step(1);
      step(0);
      step(0);

      // store, then plant 0x8A at 0x02 and fetch it alone
      c_dm = 1; c_dwe = 1; c_da = 8'hFE; c_dwd = 8'h01; step(0);
      c_dm = 1; c_dwe = 1; c_da = 8'h02; c_dwd = 8'h8A; step(0);
      step(0);
      c_if = 1; c_ia = 8'h02; step(0);
      step(0);

      // contention: dm read wins, fetch stalls one cycle
      c_dm = 1; c_da = 8'hFF; c_if = 1; c_ia = 8'h03; step(0);
      step(0);
      step(0);

      // starvation: sustained dm reads with fetch pending
      for (int unsigned i = 0; i < 10; i++) begin
         c_dm = 1; c_da = 8'(8'h20 + i);
         if (i == 0) begin c_if = 1; c_ia = 8'h10; end
         step(0);
      end
      step(0);
      step(0);

`ifdef MEM_ARB_DMA_EN
      c_dma = 1; c_aa = 8'h30; c_if = 1; c_ia = 8'h31; step(0);
      step(0);
      step(0);
`endif

      // reset the cycle after a dm read grant
      c_dm = 1; c_da = 8'h40; step(0);
      c_dm = 1; c_da = 8'h41; step(1);
      step(0);
      c_if = 1; c_ia = 8'h02; step(0);
      step(0);
      step(0);

      // random traffic, occasional reset
      for (int unsigned n = 0; n < 3000; n++) begin
         c_if = ($urandom % 4) != 0; c_ia = 8'($urandom_range(0, 15));
         c_dm = ($urandom % 2) != 0; c_dwe = ($urandom % 3) == 0;
         c_da = 8'($urandom_range(0, 15)); c_dwd = 8'($urandom);
`ifdef MEM_ARB_DMA_EN
         c_dma = ($urandom % 3) == 0; c_awe = ($urandom % 2) == 0;
         c_aa = 8'($urandom_range(0, 15)); c_awd = 8'($urandom);
`endif
         step(($urandom % 200) == 0);
      end
      step(0);
      step(0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
